// File: rtl/mc_ctrl.sv
// Multi-cycle MIPS control sequencer: five-state FSM (IF/ID/EXE/MEM/WB) that
// drives datapath write enables and mux selects, stalling on MemRdy.
module mc_ctrl (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] Op,
    input  logic [5:0] Fuc,
    input  logic       Zero,
    input  logic       MemRdy,
    output logic       PCWr,
    output logic [1:0] NPCOp,
    output logic       IRWr,
    output logic       RegWr,
    output logic       MemWr,
    output logic       RegDst,
    output logic       ALUSrc,
    output logic       MemtoReg,
    output logic       ExtOp,
    output logic [2:0] ALUctr,
    output logic       InstrDone,
    output logic       Illegal,
    output logic [2:0] State
);

    typedef enum logic [2:0] {
        S_IF  = 3'd0,
        S_ID  = 3'd1,
        S_EXE = 3'd2,
        S_MEM = 3'd3,
        S_WB  = 3'd4
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ADDIU = 6'b001001;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] FN_ADDU = 6'b100001;
    localparam logic [5:0] FN_SUBU = 6'b100011;
    localparam logic [5:0] FN_AND  = 6'b100100;
    localparam logic [5:0] FN_OR   = 6'b100101;
    localparam logic [5:0] FN_SLT  = 6'b101010;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_OR  = 3'b010;
    localparam logic [2:0] ALU_AND = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b100;

    state_t state_reg, state_next;

    logic is_rtype, is_addiu, is_ori, is_lw, is_sw, is_beq, is_j, is_legal;
    logic [2:0] alu_dec;
    logic       alusrc_dec, extop_dec;

    logic pcwr_raw, irwr_raw, regwr_raw, memwr_raw, done_raw, illegal_raw;

    always_ff @(posedge clk) begin
        if (rst) state_reg <= S_IF;
        else     state_reg <= state_next;
    end

    assign is_addiu = (Op == OP_ADDIU);
    assign is_ori   = (Op == OP_ORI);
    assign is_lw    = (Op == OP_LW);
    assign is_sw    = (Op == OP_SW);
    assign is_beq   = (Op == OP_BEQ);
    assign is_j     = (Op == OP_J);

    // ALU selects decoded once; EXE and MEM both present them
    always_comb begin
        is_rtype   = 1'b0;
        alu_dec    = ALU_ADD;
        alusrc_dec = 1'b0;
        extop_dec  = 1'b0;
        if (Op == OP_RTYPE) begin
            is_rtype = 1'b1;
            case (Fuc)
                FN_ADDU: alu_dec = ALU_ADD;
                FN_SUBU: alu_dec = ALU_SUB;
                FN_AND:  alu_dec = ALU_AND;
                FN_OR:   alu_dec = ALU_OR;
                FN_SLT:  alu_dec = ALU_SLT;
                default: is_rtype = 1'b0;
            endcase
        end else if (is_addiu || is_lw || is_sw) begin
            alu_dec    = ALU_ADD;
            alusrc_dec = 1'b1;
            extop_dec  = 1'b1;
        end else if (is_ori) begin
            alu_dec    = ALU_OR;
            alusrc_dec = 1'b1;
        end else if (is_beq) begin
            alu_dec   = ALU_SUB;
            extop_dec = 1'b1;
        end
    end

    assign is_legal = is_rtype | is_addiu | is_ori | is_lw | is_sw | is_beq | is_j;

    always_comb begin
        state_next  = state_reg;
        pcwr_raw    = 1'b0;
        irwr_raw    = 1'b0;
        regwr_raw   = 1'b0;
        memwr_raw   = 1'b0;
        done_raw    = 1'b0;
        illegal_raw = 1'b0;
        NPCOp       = 2'b00;
        RegDst      = 1'b0;
        ALUSrc      = 1'b0;
        MemtoReg    = 1'b0;
        ExtOp       = 1'b0;
        ALUctr      = ALU_ADD;
        case (state_reg)
            S_IF: begin
                irwr_raw = MemRdy;
                pcwr_raw = MemRdy;
                if (MemRdy) state_next = S_ID;
            end
            S_ID: begin
                if (is_j) begin
                    pcwr_raw   = 1'b1;
                    NPCOp      = 2'b10;
                    done_raw   = 1'b1;
                    state_next = S_IF;
                end else if (!is_legal) begin
                    illegal_raw = 1'b1;
                    state_next  = S_IF;
                end else begin
                    state_next = S_EXE;
                end
            end
            S_EXE: begin
                ALUctr = alu_dec;
                ALUSrc = alusrc_dec;
                ExtOp  = extop_dec;
                if (is_beq) begin
                    pcwr_raw   = Zero;
                    NPCOp      = 2'b01;
                    done_raw   = 1'b1;
                    state_next = S_IF;
                end else if (is_lw || is_sw) begin
                    state_next = S_MEM;
                end else begin
                    state_next = S_WB;
                end
            end
            S_MEM: begin
                ALUctr = alu_dec;
                ALUSrc = alusrc_dec;
                ExtOp  = extop_dec;
                memwr_raw = is_sw;
                if (MemRdy) begin
                    done_raw   = is_sw;
                    state_next = is_sw ? S_IF : S_WB;
                end
            end
            S_WB: begin
                regwr_raw  = 1'b1;
                done_raw   = 1'b1;
                RegDst     = (Op == OP_RTYPE);
                MemtoReg   = is_lw;
                state_next = S_IF;
            end
            default: state_next = S_IF;
        endcase
    end

    // Reset masks every write and pulse so an aborted instruction leaves no trace
    assign PCWr      = pcwr_raw    & ~rst;
    assign IRWr      = irwr_raw    & ~rst;
    assign RegWr     = regwr_raw   & ~rst;
    assign MemWr     = memwr_raw   & ~rst;
    assign InstrDone = done_raw    & ~rst;
    assign Illegal   = illegal_raw & ~rst;
    assign State     = state_reg;

endmodule

// File: tb/tb_mc_ctrl.sv
// Self-checking bench for mc_ctrl: per-instruction expected output traces are
// built from the instruction-level behaviour and compared cycle by cycle.
module tb_mc_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [5:0] Op, Fuc;
    logic       Zero, MemRdy;
    logic       PCWr, IRWr, RegWr, MemWr, RegDst, ALUSrc, MemtoReg, ExtOp;
    logic       InstrDone, Illegal;
    logic [1:0] NPCOp;
    logic [2:0] ALUctr, State;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mc_ctrl dut (
        .clk(clk), .rst(rst), .Op(Op), .Fuc(Fuc), .Zero(Zero), .MemRdy(MemRdy),
        .PCWr(PCWr), .NPCOp(NPCOp), .IRWr(IRWr), .RegWr(RegWr), .MemWr(MemWr),
        .RegDst(RegDst), .ALUSrc(ALUSrc), .MemtoReg(MemtoReg), .ExtOp(ExtOp),
        .ALUctr(ALUctr), .InstrDone(InstrDone), .Illegal(Illegal), .State(State)
    );

    typedef struct packed {
        logic [2:0] st;
        logic       pcwr;
        logic [1:0] npc;
        logic       irwr;
        logic       regwr;
        logic       memwr;
        logic       regdst;
        logic       alusrc;
        logic       memtoreg;
        logic       extop;
        logic [2:0] alu;
        logic       done;
        logic       ill;
    } obs_t;

    // instruction classes used by the model
    localparam int C_ILL = 0, C_R = 1, C_ADDIU = 2, C_ORI = 3, C_LW = 4,
                   C_SW = 5, C_BEQ = 6, C_J = 7;

    obs_t exp_q[$];
    logic rdy_q[$];

    function automatic obs_t get_obs();
        return '{st: State, pcwr: PCWr, npc: NPCOp, irwr: IRWr, regwr: RegWr,
                 memwr: MemWr, regdst: RegDst, alusrc: ALUSrc, memtoreg: MemtoReg,
                 extop: ExtOp, alu: ALUctr, done: InstrDone, ill: Illegal};
    endfunction

    function automatic int classify(input logic [5:0] op, input logic [5:0] fuc);
        case (op)
            6'h00: return (fuc == 6'h21 || fuc == 6'h23 || fuc == 6'h24 ||
                           fuc == 6'h25 || fuc == 6'h2a) ? C_R : C_ILL;
            6'h09: return C_ADDIU;
            6'h0d: return C_ORI;
            6'h23: return C_LW;
            6'h2b: return C_SW;
            6'h04: return C_BEQ;
            6'h02: return C_J;
            default: return C_ILL;
        endcase
    endfunction

    function automatic obs_t blank(input logic [2:0] st);
        obs_t o;
        o = '0;
        o.st = st;
        return o;
    endfunction

    // ALU operation the instruction performs, as the ISA defines it
    function automatic obs_t with_alu(input obs_t o, input int cls, input logic [5:0] fuc);
        obs_t r;
        r = o;
        case (cls)
            C_R: begin
                r.alusrc = 1'b0;
                r.alu = (fuc == 6'h21) ? 3'd0 : (fuc == 6'h23) ? 3'd1 :
                        (fuc == 6'h25) ? 3'd2 : (fuc == 6'h24) ? 3'd3 : 3'd4;
            end
            C_ADDIU, C_LW, C_SW: begin r.alu = 3'd0; r.alusrc = 1'b1; r.extop = 1'b1; end
            C_ORI:               begin r.alu = 3'd2; r.alusrc = 1'b1; r.extop = 1'b0; end
            C_BEQ:               begin r.alu = 3'd1; r.alusrc = 1'b0; r.extop = 1'b1; end
            default: ;
        endcase
        return r;
    endfunction

    task automatic build_model(input logic [5:0] op, input logic [5:0] fuc,
                               input logic zero, input int wif, input int wmem);
        int   cls;
        obs_t o;
        cls = classify(op, fuc);
        exp_q.delete();
        rdy_q.delete();
        for (int k = 0; k <= wif; k++) begin
            o = blank(3'd0);
            o.irwr = (k == wif);
            o.pcwr = (k == wif);
            exp_q.push_back(o);
            rdy_q.push_back(k == wif);
        end
        o = blank(3'd1);
        if (cls == C_J) begin o.pcwr = 1'b1; o.npc = 2'b10; o.done = 1'b1; end
        if (cls == C_ILL) o.ill = 1'b1;
        exp_q.push_back(o);
        rdy_q.push_back(1'($urandom));
        if (cls == C_J || cls == C_ILL) return;
        o = with_alu(blank(3'd2), cls, fuc);
        if (cls == C_BEQ) begin o.pcwr = zero; o.npc = 2'b01; o.done = 1'b1; end
        exp_q.push_back(o);
        rdy_q.push_back(1'($urandom));
        if (cls == C_BEQ) return;
        if (cls == C_LW || cls == C_SW) begin
            for (int k = 0; k <= wmem; k++) begin
                o = with_alu(blank(3'd3), cls, fuc);
                if (cls == C_SW) begin o.memwr = 1'b1; o.done = (k == wmem); end
                exp_q.push_back(o);
                rdy_q.push_back(k == wmem);
            end
            if (cls == C_SW) return;
        end
        o = blank(3'd4);
        o.regwr    = 1'b1;
        o.done     = 1'b1;
        o.regdst   = (cls == C_R);
        o.memtoreg = (cls == C_LW);
        exp_q.push_back(o);
        rdy_q.push_back(1'($urandom));
    endtask

    // Runs one instruction from its first IF cycle; limit > 0 aborts after that many cycles.
    // Entered and left at #1 after a rising edge.
    task automatic run_instr(input string name, input logic [5:0] op, input logic [5:0] fuc,
                             input logic zero, input int wif, input int wmem, input int limit);
        obs_t o;
        int   cls, n, done_at, exp_done, base;
        cls = classify(op, fuc);
        build_model(op, fuc, zero, wif, wmem);
        n = exp_q.size();
        if (limit > 0 && limit < n) n = limit;
        done_at = -1;
        Op  = op;
        Fuc = fuc;
        for (int i = 0; i < n; i++) begin
            MemRdy = rdy_q[i];
            Zero   = (cls == C_BEQ) ? zero : 1'($urandom);
            @(negedge clk);
            o = get_obs();
            checks++;
            if (o !== exp_q[i]) begin
                failures++;
                $display("FAIL %s cycle%0d outputs got=%h required=%h", name, i, o, exp_q[i]);
            end
            if (o.done && done_at < 0) done_at = i + 1;
            @(posedge clk);
            #1;
        end
        if (limit == 0) begin
            case (cls)
                C_J:     base = 2;
                C_BEQ:   base = 3;
                C_LW:    base = 5 + wmem;
                C_SW:    base = 4 + wmem;
                default: base = 4;
            endcase
            exp_done = (cls == C_ILL) ? -1 : base + wif;
            checks++;
            if (done_at !== exp_done) begin
                failures++;
                $display("FAIL %s latency got=%0d required=%0d", name, done_at, exp_done);
            end
            $display("instr %-8s op=%b fuc=%b zero=%0b wif=%0d wmem=%0d done_cycle=%0d",
                     name, op, fuc, zero, wif, wmem, done_at);
        end else begin
            $display("instr %-8s op=%b aborted after %0d cycles", name, op, n);
        end
    endtask

    // Assert reset for three cycles starting in the current cycle
    task automatic hold_reset(input string name, input logic [2:0] first_state);
        logic [5:0] we;
        rst    = 1'b1;
        MemRdy = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            we = {PCWr, IRWr, RegWr, MemWr, InstrDone, Illegal};
            checks++;
            if (we !== 6'b0) begin
                failures++;
                $display("FAIL %s writes_in_reset c%0d got=%b required=000000", name, c, we);
            end
            checks++;
            if (State !== ((c == 0) ? first_state : 3'd0)) begin
                failures++;
                $display("FAIL %s state_in_reset c%0d got=%0d required=%0d", name, c, State,
                         (c == 0) ? first_state : 3'd0);
            end
            @(posedge clk);
            #1;
        end
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; Op = 6'h0; Fuc = 6'h0; Zero = 1'b0; MemRdy = 1'b0;
        @(posedge clk);
        #1;
        hold_reset("reset_if", 3'd0);
        run_instr("addu_rst", 6'h00, 6'h21, 1'b0, 0, 0, 0);
        run_instr("lw_abort", 6'h23, 6'h00, 1'b0, 0, 5, 4);
        hold_reset("reset_lw", 3'd3);
        run_instr("ori_rst", 6'h0d, 6'h15, 1'b0, 0, 0, 0);
        run_instr("sw_abort", 6'h2b, 6'h00, 1'b0, 0, 5, 4);
        hold_reset("reset_sw", 3'd3);
    endtask

    task automatic test_alu();
        run_instr("addu",  6'h00, 6'h21, 1'b0, 0, 0, 0);
        run_instr("subu",  6'h00, 6'h23, 1'b1, 1, 0, 0);
        run_instr("and",   6'h00, 6'h24, 1'b0, 0, 0, 0);
        run_instr("or",    6'h00, 6'h25, 1'b0, 2, 0, 0);
        run_instr("slt",   6'h00, 6'h2a, 1'b0, 0, 0, 0);
        run_instr("addiu", 6'h09, 6'h3f, 1'b0, 0, 0, 0);
    endtask

    task automatic test_memory();
        run_instr("lw",  6'h23, 6'h00, 1'b0, 0, 2, 0);
        run_instr("sw",  6'h2b, 6'h00, 1'b0, 0, 1, 0);
        run_instr("lw0", 6'h23, 6'h00, 1'b0, 1, 0, 0);
    endtask

    task automatic test_branch_jump();
        run_instr("beq_t",  6'h04, 6'h00, 1'b1, 0, 0, 0);
        run_instr("beq_nt", 6'h04, 6'h00, 1'b0, 0, 0, 0);
        run_instr("j",      6'h02, 6'h00, 1'b0, 0, 0, 0);
        run_instr("ill_op", 6'h3f, 6'h21, 1'b0, 0, 0, 0);
        run_instr("ill_fn", 6'h00, 6'h20, 1'b0, 0, 0, 0);
    endtask

    task automatic test_back_to_back();
        logic [5:0] fn;
        logic [5:0] op;
        logic [5:0] rfn [5];
        logic [5:0] iop [4];
        rfn = '{6'h21, 6'h23, 6'h24, 6'h25, 6'h2a};
        iop = '{6'h09, 6'h0d, 6'h23, 6'h2b};
        for (int t = 0; t < 60; t++) begin
            fn = 6'($urandom);
            case ($urandom_range(0, 6))
                0: begin op = 6'h00; fn = rfn[$urandom_range(0, 4)]; end
                1, 2: op = iop[$urandom_range(0, 3)];
                3: op = 6'h04;
                4: op = 6'h02;
                5: op = 6'h00;
                default: op = 6'($urandom);
            endcase
            run_instr("random", op, fn, 1'($urandom), $urandom_range(0, 2),
                      $urandom_range(0, 2), 0);
        end
    endtask

    initial begin
        test_reset();
        test_alu();
        test_memory();
        test_branch_jump();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
